// File: rtl/aes_sub_bytes_if.sv
// Bus bundle for the AES SubBytes stage: input state plus its qualifier,
// and the registered output state plus its qualifier.
interface aes_sub_bytes_if;
  logic         in_valid;
  logic [127:0] in;
  logic [127:0] out;
  logic         out_valid;

  // Producer side: drives the state into the stage and observes the result.
  modport master (
    output in_valid,
    output in,
    input  out,
    input  out_valid
  );

  // Stage side: consumes the state and returns the substituted state.
  modport slave (
    input  in_valid,
    input  in,
    output out,
    output out_valid
  );
endinterface

// File: rtl/aes_sub_bytes.sv
// AES-128 forward SubBytes stage. Each of the 16 state bytes is passed through
// the forward S-box in parallel and the result is registered (1-cycle latency).
// The output register is free-running; out_valid simply follows in_valid.
module aes_sub_bytes (
  input  logic            clk,
  input  logic            rst_n,
  aes_sub_bytes_if.slave  bus
);

  // Forward S-box, entry 0x00 in the most significant byte, 0xFF in the least.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Combinational ROM lookup. Entry b sits at bit offset (255-b)*8, which is
  // just the inverted byte shifted left by three.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] offset;
    offset = {~b, 3'b000};
    return SBOX_TABLE[offset +: 8];
  endfunction

  logic [127:0] sub_next;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      // One independent lookup per byte lane; no reordering across lanes.
      assign sub_next[8*gi +: 8] = sbox(bus.in[8*gi +: 8]);
    end
  endgenerate

  // Output register: captures the substituted state every cycle, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= 128'h0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out       <= sub_next;
      bus.out_valid <= bus.in_valid;
    end
  end

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Self-checking bench for aes_sub_bytes. The reference S-box is derived from
// its mathematical definition (GF(2^8) inverse followed by the affine map)
// rather than from a lookup table.
module tb_aes_sub_bytes;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  logic [7:0] ref_sbox [256];

  aes_sub_bytes_if bus ();

  aes_sub_bytes dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply with the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S(b) = affine(inverse(b)), with inverse(0) defined as 0.
  function automatic logic [7:0] sbox_math(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    if (b != 8'h00) begin
      for (int c = 1; c < 256; c++) begin
        if (gf_mul(b, 8'(c)) == 8'h01) inv = 8'(c);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sbox[s[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one state between edges, let one rising edge pass, then check 1-cycle result.
  task automatic step(input string tag, input logic [127:0] data, input logic valid,
                      input logic [127:0] exp);
    @(negedge clk);
    bus.in       = data;
    bus.in_valid = valid;
    @(posedge clk);
    #1;
    check({tag, "_out"}, bus.out, exp);
    check({tag, "_valid"}, {127'h0, bus.out_valid}, {127'h0, valid});
    $display("step %s in=%h valid=%0b out=%h out_valid=%0b", tag, data, valid, bus.out, bus.out_valid);
  endtask

  initial begin
    logic [127:0] d;
    logic         v;
    compared   = 0;
    mismatched = 0;
    for (int b = 0; b < 256; b++) ref_sbox[b] = sbox_math(8'(b));

    // Sanity of the reference model against the published anchors.
    check("model_anchors",
          {96'h0, ref_sbox[8'h00], ref_sbox[8'h01], ref_sbox[8'h10], ref_sbox[8'h53]},
          {96'h0, 8'h63, 8'h7c, 8'hca, 8'hed});

    // Reset held low across clock edges.
    rst_n        = 1'b0;
    bus.in       = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", bus.out, 128'h0);
    check("reset_valid", {127'h0, bus.out_valid}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 example round states.
    step("fips_r1", 128'h00102030405060708090a0b0c0d0e0f0, 1'b1, 128'h63cab7040953d051cd60e0e7ba70e18c);
    step("fips_r2", 128'h89d810e8855ace682d1843d8cb128fe4, 1'b1, 128'ha761ca9b97be8b45d8ad1a611fc97369);
    step("fips_r10", 128'hbd6e7c3df2b5779e0b61216e8b10b689, 1'b1, 128'h7a9f102789d5f50b2beffd9f3dca4ea7);

    // Corner states.
    step("all00", {16{8'h00}}, 1'b1, {16{8'h63}});
    step("allff", {16{8'hff}}, 1'b1, {16{8'h16}});
    // Datapath is free-running: out still follows in when in_valid is low.
    step("novalid", 128'h00102030405060708090a0b0c0d0e0f0, 1'b0, 128'h63cab7040953d051cd60e0e7ba70e18c);

    // Asynchronous reset between edges: out must clear with no clock edge.
    step("pre_async", {16{8'h53}}, 1'b1, {16{8'hed}});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out", bus.out, 128'h0);
    check("async_valid", {127'h0, bus.out_valid}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep: every byte value in all lanes, back-to-back.
    for (int b = 0; b < 256; b++) begin
      d = {16{8'(b)}};
      v = 1'(b % 3 != 0);
      step($sformatf("sweep_%02h", b), d, v, {16{ref_sbox[b]}});
    end

    // Random streaming with a mid-stream reset pulse.
    for (int n = 0; n < 40; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      v = 1'($urandom_range(0, 1));
      step($sformatf("rand_%0d", n), d, v, model(d));
      if (n == 20) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out", bus.out, 128'h0);
        check("midreset_valid", {127'h0, bus.out_valid}, 128'h0);
        // A valid input sampled while in reset must be discarded.
        @(negedge clk);
        bus.in       = 128'h0123456789abcdef0123456789abcdef;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_hold_out", bus.out, 128'h0);
        check("midreset_hold_valid", {127'h0, bus.out_valid}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
